// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the M stage: one load/store at a time, stall while busy.
// Optional build macro DMEM_MISALIGN_ERR_EN: misaligned word accesses complete with rsp_err instead of touching memory.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);
  // state | meaning
  // IDLE  | ready for a request
  // BUSY  | latency countdown
  // RESP  | completion cycle, rsp_valid high
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            lat_we;
  logic            lat_byte;
  logic [AW+1:0]   lat_addr;
  logic [31:0]     lat_wdata;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            op_we;
  logic            op_byte;
  logic [AW+1:0]   op_addr;
  logic [31:0]     op_wdata;
  logic [AW-1:0]   idx;
  logic            enter_resp;
  logic            misalign;
  logic            do_write;
  logic            unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];

  // With LATENCY = 1 the RESP-entry edge is the acceptance edge, so use the live request.
  always_comb begin
    op_we    = lat_we;
    op_byte  = lat_byte;
    op_addr  = lat_addr;
    op_wdata = lat_wdata;
    if (state == IDLE) begin
      op_we    = req_we;
      op_byte  = req_byte;
      op_addr  = req_addr[AW+1:0];
      op_wdata = req_wdata;
    end
  end

  assign idx        = op_addr[AW+1:2];
  assign enter_resp = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                      ((state == BUSY) && (cnt == '0));

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign = !op_byte && (op_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign do_write  = enter_resp && op_we && !misalign && !reset;
  assign req_ready = (state == IDLE);
  assign stall     = req_valid && !rsp_valid;

  // Memory has no reset; big-endian lanes (addr 0 -> bits [31:24]).
  always_ff @(posedge clk) begin
    if (do_write) begin
      if (op_byte) begin
        case (op_addr[1:0])
          2'b00:   mem[idx][31:24] <= op_wdata[7:0];
          2'b01:   mem[idx][23:16] <= op_wdata[7:0];
          2'b10:   mem[idx][15:8]  <= op_wdata[7:0];
          default: mem[idx][7:0]   <= op_wdata[7:0];
        endcase
      end else begin
        mem[idx] <= op_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_byte  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      rsp_valid <= enter_resp;
      rsp_err   <= enter_resp && misalign;
      if (enter_resp) rsp_rdata <= misalign ? 32'h0 : mem[idx];
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_byte  <= req_byte;
            lat_addr  <= req_addr[AW+1:0];
            lat_wdata <= req_wdata;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance for data/timing/reset, LATENCY=1 instance for back-to-back.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          known;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_byte;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;

  logic        r1_valid, r1_we, r1_byte;
  logic [31:0] r1_addr, r1_wdata;
  logic        r1_ready, r1_rsp_valid, r1_rsp_err, r1_stall;
  logic [31:0] r1_rsp_rdata;

  int checks = 0;
  int errors = 0;
  exp_t        sb[$];
  logic [31:0] mdl[int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(r1_valid), .req_we(r1_we), .req_byte(r1_byte),
    .req_addr(r1_addr), .req_wdata(r1_wdata), .req_ready(r1_ready), .rsp_valid(r1_rsp_valid),
    .rsp_rdata(r1_rsp_rdata), .rsp_err(r1_rsp_err), .stall(r1_stall));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitor: pop one expectation per completion pulse.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.known) check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic push_exp(input bit we, input bit b, input logic [31:0] addr, input logic [31:0] wd);
    int          idx;
    exp_t        e;
    logic [31:0] w;
    idx     = int'((addr >> 2) & 32'(DEPTH - 1));
    e.known = mdl.exists(idx);
    e.rdata = e.known ? mdl[idx] : 32'h0;
    e.err   = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    if (!b && addr[1:0] != 2'b00) begin
      e.err   = 1'b1;
      e.rdata = 32'h0;
      e.known = 1'b1;
      we      = 1'b0;
    end
`endif
    if (we) begin
      w = e.known ? mdl[idx] : 32'hx;
      if (!b) w = wd;
      else case (addr[1:0])
        2'b00:   w[31:24] = wd[7:0];
        2'b01:   w[23:16] = wd[7:0];
        2'b10:   w[15:8]  = wd[7:0];
        default: w[7:0]   = wd[7:0];
      endcase
      mdl[idx] = w;
    end
    sb.push_back(e);
  endtask

  task automatic do_req(input bit we, input bit b, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    bit got;
    @(negedge clk);
    push_exp(we, b, addr, wd);
    req_valid = 1'b1; req_we = we; req_byte = b; req_addr = addr; req_wdata = wd;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
    check("accept", 32'(req_ready), 32'd1);
    check("stall_accept", 32'(stall), 32'd1);
    @(posedge clk);
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk); #1; n++;
      check("ready_low", 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        got = 1'b1;
        check("stall_resp", 32'(stall), 32'd0);
      end else begin
        check("stall_busy", 32'(stall), 32'd1);
      end
    end
    check("rsp_seen", 32'(rsp_valid), 32'd1);
    check("latency", 32'(n), 32'(LAT));
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_byte = 1'b0; r1_addr = '0; r1_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);

    // Word store/load, then big-endian byte merges
    do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 1'b1, 32'h10, 32'h00000011);
    do_req(1'b1, 1'b1, 32'h13, 32'hAAAAAA22);
    do_req(1'b0, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 1'b1, 32'h11, 32'h0);

    // Address wrap at DEPTH*4 bytes
    do_req(1'b1, 1'b0, 32'h0, 32'h12345678);
    do_req(1'b0, 1'b0, 32'h1000, 32'h0);
    do_req(1'b1, 1'b0, 32'h1004, 32'h0BADF00D);
    do_req(1'b0, 1'b0, 32'h4, 32'h0);

    // Reset one cycle after accepting a store: store must be dropped
    do_req(1'b1, 1'b0, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
    #1;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_rdata", rsp_rdata, 32'h0);
    check("rst_mid_idle", 32'(req_ready), 32'd1);
    reset = 1'b0;
    do_req(1'b0, 1'b0, 32'h20, 32'h0);

    // Misaligned word store; outcome depends on build option
    do_req(1'b1, 1'b0, 32'h22, 32'h55AA55AA);
    do_req(1'b0, 1'b0, 32'h20, 32'h0);
    do_req(1'b1, 1'b1, 32'h22, 32'h00000077);
    do_req(1'b0, 1'b0, 32'h20, 32'h0);

    // LATENCY=1: store then loads held valid, one response every two cycles
    @(negedge clk);
    r1_valid = 1'b1; r1_we = 1'b1; r1_byte = 1'b0; r1_addr = 32'h4; r1_wdata = 32'hA5A50001;
    #1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      check("l1_rsp_valid", 32'(r1_rsp_valid), 32'(k % 2));
      check("l1_stall", 32'(r1_stall), 32'((k % 2) == 0));
      check("l1_ready", 32'(r1_ready), 32'((k % 2) == 0));
      if (k >= 3 && (k % 2) == 1) check("l1_rdata", r1_rsp_rdata, 32'hA5A50001);
      if (k == 1) r1_we = 1'b0;
    end
    r1_valid = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
